// File: rtl/mem_responder.sv
// mem_responder: byte-wide bus responder with a synchronous single-port RAM
// and a memory-mapped transmit channel backed by a small FIFO.
// Address bit 17 splits RAM (0) from I/O (1); within I/O, bit 2 picks
// TX data (0) or the halt register (1).
module mem_responder #(
  parameter int RAM_AW     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        mem_rw,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic        io_tx_valid,
  output logic [7:0]  io_tx_data,
  input  logic        io_tx_ready,
  output logic        io_overflow,
  output logic        io_halt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_THR = (PTR_W+1)'(FIFO_DEPTH - 2);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [7:0] ram [0:(1<<RAM_AW)-1];
  logic [7:0] fifo_mem [0:FIFO_DEPTH-1];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic              io_sel;
  logic              halt_sel;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic              rd_en;
  logic              push_req;
  logic              halt_we;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic              unused_addr;

  assign io_sel      = mem_addr[17];
  assign halt_sel    = mem_addr[2];
  assign ram_addr    = mem_addr[RAM_AW-1:0];
  assign unused_addr = ^mem_addr[31:18];

  assign ram_we   = rdy & mem_rw & ~io_sel;
  assign rd_en    = rdy & ~mem_rw;
  assign push_req = rdy & mem_rw & io_sel & ~halt_sel;
  assign halt_we  = rdy & mem_rw & io_sel & halt_sel;

  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign pop     = io_tx_valid & io_tx_ready;
  assign push_ok = push_req & ((count < DEPTH_C) | pop);
  assign drop    = push_req & ~push_ok;

  // Status is derived from the registered count only, keeping bus inputs
  // off the back-pressure path.
  assign io_tx_valid    = (count != '0);
  assign io_tx_data     = fifo_mem[rd_ptr];
  assign io_buffer_full = (count >= FULL_THR);

  // RAM array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= mem_din;
    end
  end

  // Registered read data; I/O reads return zero and writes leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_dout <= 8'h00;
    end else if (rd_en) begin
      mem_dout <= io_sel ? 8'h00 : ram[ram_addr];
    end
  end

  // FIFO storage write port; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= mem_din;
    end
  end

  // FIFO pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow and halt flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_overflow <= 1'b0;
      io_halt     <= 1'b0;
    end else begin
      if (drop) begin
        io_overflow <= 1'b1;
      end
      if (halt_we) begin
        io_halt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table for the documented scenarios,
// an asynchronous-reset sequence, then randomized traffic checked against
// a queue-based reference model.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        io_buffer_full;
  logic        io_tx_valid;
  logic [7:0]  io_tx_data;
  logic        io_tx_ready;
  logic        io_overflow;
  logic        io_halt;

  int n_vec;
  int n_fail;

  typedef struct {
    logic        rdy;
    logic        rw;
    logic [31:0] addr;
    logic [7:0]  din;
    logic        txr;
    logic [7:0]  e_dout;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_full;
    logic        e_ovf;
    logic        e_halt;
  } vec_t;

  vec_t tbl[$];

  logic [7:0]  q[$];
  logic [7:0]  ram_m [logic [16:0]];
  logic [16:0] pool [16];
  logic [7:0]  m_dout;
  logic        m_ovf;
  logic        m_halt;

  mem_responder dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_rw         (mem_rw),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .io_buffer_full (io_buffer_full),
    .io_tx_valid    (io_tx_valid),
    .io_tx_data     (io_tx_data),
    .io_tx_ready    (io_tx_ready),
    .io_overflow    (io_overflow),
    .io_halt        (io_halt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic r, logic w, logic [31:0] a, logic [7:0] d, logic t,
                              logic [7:0] ed, logic ev, logic [7:0] edata,
                              logic ef, logic eo, logic eh);
    vec_t v;
    v.rdy = r; v.rw = w; v.addr = a; v.din = d; v.txr = t;
    v.e_dout = ed; v.e_valid = ev; v.e_data = edata;
    v.e_full = ef; v.e_ovf = eo; v.e_halt = eh;
    return v;
  endfunction

  // Drive one bus cycle, then return 1 ns after the sampling edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [7:0] d, input logic t);
    rdy = r; mem_rw = w; mem_addr = a; mem_din = d; io_tx_ready = t;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " dout"},  mem_dout,       8'h00);
    checkOutput({tag, " valid"}, io_tx_valid,    8'h00);
    checkOutput({tag, " full"},  io_buffer_full, 8'h00);
    checkOutput({tag, " ovf"},   io_overflow,    8'h00);
    checkOutput({tag, " halt"},  io_halt,        8'h00);
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst = 1'b0;
    rdy = 1'b0; mem_rw = 1'b0; mem_addr = '0; mem_din = '0; io_tx_ready = 1'b0;
    #12 rst = 1'b1;
    checkAllZero("reset");

    // Directed scenarios with hand-derived expected outputs.
    tbl.push_back(mk(1, 1, 32'h00020, 8'h11, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h00010, 8'hA5, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h00010, 8'h00, 0, 8'hA5, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h1FFFF, 8'h3C, 0, 8'hA5, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h1FFFF, 8'h00, 0, 8'h3C, 0, 8'h00, 0, 0, 0));
    for (int k = 1; k <= 6; k++) begin
      tbl.push_back(mk(1, 1, 32'h30000, 8'(k), 0, 8'h3C, 1, 8'h01, (k == 6), 0, 0));
    end
    tbl.push_back(mk(1, 1, 32'h30000, 8'h07, 0, 8'h3C, 1, 8'h01, 1, 0, 0));
    tbl.push_back(mk(1, 1, 32'h30000, 8'h08, 0, 8'h3C, 1, 8'h01, 1, 0, 0));
    tbl.push_back(mk(1, 1, 32'h30000, 8'h09, 0, 8'h3C, 1, 8'h01, 1, 1, 0));
    tbl.push_back(mk(1, 1, 32'h30000, 8'h55, 1, 8'h3C, 1, 8'h02, 1, 1, 0));
    tbl.push_back(mk(0, 1, 32'h00020, 8'h77, 1, 8'h3C, 1, 8'h03, 1, 1, 0));
    tbl.push_back(mk(0, 1, 32'h30000, 8'hEE, 1, 8'h3C, 1, 8'h04, 1, 1, 0));
    tbl.push_back(mk(0, 0, 32'h00000, 8'h00, 1, 8'h3C, 1, 8'h05, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h00000, 8'h00, 1, 8'h3C, 1, 8'h06, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h00000, 8'h00, 1, 8'h3C, 1, 8'h07, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h00000, 8'h00, 1, 8'h3C, 1, 8'h08, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h00000, 8'h00, 1, 8'h3C, 1, 8'h55, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h00000, 8'h00, 1, 8'h3C, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 0, 32'h00020, 8'h00, 0, 8'h11, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 1, 32'h30004, 8'h00, 0, 8'h11, 0, 8'h00, 0, 1, 1));
    tbl.push_back(mk(1, 0, 32'h30000, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 1));
    tbl.push_back(mk(1, 0, 32'hFFFC0010, 8'h00, 0, 8'hA5, 0, 8'h00, 0, 1, 1));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rdy, tbl[i].rw, tbl[i].addr, tbl[i].din, tbl[i].txr);
      checkOutput($sformatf("vec%0d dout", i),  mem_dout,       tbl[i].e_dout);
      checkOutput($sformatf("vec%0d valid", i), io_tx_valid,    tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        checkOutput($sformatf("vec%0d data", i), io_tx_data, tbl[i].e_data);
      end
      checkOutput($sformatf("vec%0d full", i),  io_buffer_full, tbl[i].e_full);
      checkOutput($sformatf("vec%0d ovf", i),   io_overflow,    tbl[i].e_ovf);
      checkOutput($sformatf("vec%0d halt", i),  io_halt,        tbl[i].e_halt);
    end

    // Queue three bytes, then pull reset low between clock edges.
    applyStimulus(1, 1, 32'h30000, 8'hAA, 0);
    applyStimulus(1, 1, 32'h30000, 8'hBB, 0);
    applyStimulus(1, 1, 32'h30000, 8'hCC, 0);
    checkOutput("queued valid", io_tx_valid, 8'h01);
    checkOutput("queued head", io_tx_data, 8'hAA);
    applyStimulus(0, 0, 32'h0, 8'h00, 0);
    #2 rst = 1'b0;
    #1;
    checkAllZero("async reset");
    #3 rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 8'h00, 1);
    checkOutput("post reset valid", io_tx_valid, 8'h00);
    checkOutput("post reset ovf", io_overflow, 8'h00);

    // Randomized traffic against a queue/array reference model.
    rst = 1'b0;
    #3 rst = 1'b1;
    q.delete();
    ram_m.delete();
    m_dout = 8'h00; m_ovf = 1'b0; m_halt = 1'b0;
    for (int i = 0; i < 16; i++) pool[i] = 17'($urandom);

    for (int n = 0; n < 1500; n++) begin
      logic        r, w, t, isio, ishalt, dopop, preq, accept;
      logic [31:0] a;
      logic [7:0]  d;
      ishalt = 1'b0;
      if (n < 16) begin
        r = 1'b1; w = 1'b1; isio = 1'b0;
        a = {14'($urandom), 1'b0, pool[n]};
      end else begin
        r = ($urandom_range(0, 9) < 8);
        w = 1'($urandom_range(0, 1));
        isio = ($urandom_range(0, 9) < 5);
        if (isio) begin
          ishalt = ($urandom_range(0, 99) == 0);
          a = {14'($urandom), 1'b1, 14'($urandom), ishalt, 2'($urandom)};
        end else begin
          a = {14'($urandom), 1'b0, pool[$urandom_range(0, 15)]};
        end
      end
      d = 8'($urandom);
      t = ($urandom_range(0, 9) < 4);

      dopop  = (q.size() != 0) && t;
      preq   = r && w && isio && !ishalt;
      accept = preq && ((q.size() < 8) || dopop);

      applyStimulus(r, w, a, d, t);

      if (dopop) q.delete(0);
      if (accept) q.push_back(d);
      if (preq && !accept) m_ovf = 1'b1;
      if (r && w && isio && ishalt) m_halt = 1'b1;
      if (r && w && !isio) ram_m[a[16:0]] = d;
      if (r && !w) m_dout = isio ? 8'h00 : ram_m[a[16:0]];

      checkOutput($sformatf("rnd%0d dout", n),  mem_dout,       m_dout);
      checkOutput($sformatf("rnd%0d valid", n), io_tx_valid,    8'(q.size() != 0));
      if (q.size() != 0) begin
        checkOutput($sformatf("rnd%0d data", n), io_tx_data, q[0]);
      end
      checkOutput($sformatf("rnd%0d full", n),  io_buffer_full, 8'(q.size() >= 6));
      checkOutput($sformatf("rnd%0d ovf", n),   io_overflow,    8'(m_ovf));
      checkOutput($sformatf("rnd%0d halt", n),  io_halt,        8'(m_halt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
